// File: rtl/divtick_serial_tx.sv
// Bit-serial transmitter clocked by the rising edges of the divider flag: start bit, LSB-first data, stop bits.
// Optional even parity before the stop bits when DIVTICK_TX_PARITY_EN is defined.
module divtick_serial_tx #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tick_lvl,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic              o_div_enable,
    output logic              o_serial_out,
    output logic              o_busy,
    output logic              o_tx_done
);

    localparam int BCW = $clog2(DATA_W + 1);

`ifdef DIVTICK_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t            r_state, w_state;
    logic              r_tick_q;
    logic [DATA_W-1:0] r_sreg, w_sreg;
    logic [BCW-1:0]    r_bit_cnt, w_bit_cnt;
    logic [1:0]        r_stop_cnt, w_stop_cnt;
    logic              r_serial, w_serial;
    logic              r_tx_ready, w_tx_ready;
    logic              r_busy, w_busy;
    logic              r_tx_done, w_tx_done;
    logic              w_tick;
`ifdef DIVTICK_TX_PARITY_EN
    logic              r_par, w_par;
`endif

    assign w_tick = i_tick_lvl & ~r_tick_q;

    always_comb begin
        w_state    = r_state;
        w_sreg     = r_sreg;
        w_bit_cnt  = r_bit_cnt;
        w_stop_cnt = r_stop_cnt;
        w_serial   = r_serial;
        w_tx_done  = 1'b0;
`ifdef DIVTICK_TX_PARITY_EN
        w_par      = r_par;
`endif
        case (r_state)
            // Ticks seen while idle are dropped, even one landing on the accept edge.
            S_IDLE: begin
                w_serial = 1'b1;
                if (i_tx_valid && r_tx_ready) begin
                    w_state    = S_WAIT;
                    w_sreg     = i_tx_data;
                    w_bit_cnt  = '0;
                    w_stop_cnt = '0;
`ifdef DIVTICK_TX_PARITY_EN
                    w_par      = ^i_tx_data;
`endif
                end
            end
            S_WAIT: begin
                if (w_tick) begin
                    w_serial = 1'b0;
                    w_state  = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_serial  = r_sreg[0];
                    w_sreg    = r_sreg >> 1;
                    w_bit_cnt = BCW'(1);
                    w_state   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt < BCW'(DATA_W)) begin
                        w_serial  = r_sreg[0];
                        w_sreg    = r_sreg >> 1;
                        w_bit_cnt = r_bit_cnt + BCW'(1);
                    end else begin
`ifdef DIVTICK_TX_PARITY_EN
                        w_serial   = r_par;
                        w_state    = S_PARITY;
`else
                        w_serial   = 1'b1;
                        w_stop_cnt = 2'd1;
                        w_state    = S_STOP;
`endif
                    end
                end
            end
`ifdef DIVTICK_TX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_serial   = 1'b1;
                    w_stop_cnt = 2'd1;
                    w_state    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (r_stop_cnt < 2'(STOP_BITS)) begin
                        w_stop_cnt = r_stop_cnt + 2'd1;
                    end else begin
                        w_state   = S_IDLE;
                        w_tx_done = 1'b1;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
        w_tx_ready = (w_state == S_IDLE);
        w_busy     = (w_state != S_IDLE);
    end

    // tick_q resets high so a flag already high at release is not taken as an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_tick_q   <= 1'b1;
            r_sreg     <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_serial   <= 1'b1;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
`ifdef DIVTICK_TX_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state;
            r_tick_q   <= i_tick_lvl;
            r_sreg     <= w_sreg;
            r_bit_cnt  <= w_bit_cnt;
            r_stop_cnt <= w_stop_cnt;
            r_serial   <= w_serial;
            r_tx_ready <= w_tx_ready;
            r_busy     <= w_busy;
            r_tx_done  <= w_tx_done;
`ifdef DIVTICK_TX_PARITY_EN
            r_par      <= w_par;
`endif
        end
    end

    assign o_tx_ready   = r_tx_ready;
    assign o_busy       = r_busy;
    assign o_div_enable = r_busy;
    assign o_serial_out = r_serial;
    assign o_tx_done    = r_tx_done;

endmodule

// File: tb/tb_divtick_serial_tx.sv
// Directed bench for divtick_serial_tx: a model divider drives tick_lvl with an 8-clk period,
// and each transmitted frame is compared bit-by-bit against hand-built expected framing.
module tb_divtick_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_lvl = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, div_enable, serial_out, busy, tx_done;

    int checks   = 0;
    int failures = 0;

    logic       div_run   = 1'b0;
    logic       tick_hold = 1'b1;
    logic [2:0] divcnt    = 3'd4;
    logic       tbq       = 1'b1;
    logic       tb_tick;

    always #5 clk = ~clk;

    divtick_serial_tx #(.DATA_W(8), .STOP_BITS(1)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_tick_lvl   (tick_lvl),
        .i_tx_data    (tx_data),
        .i_tx_valid   (tx_valid),
        .o_tx_ready   (tx_ready),
        .o_div_enable (div_enable),
        .o_serial_out (serial_out),
        .o_busy       (busy),
        .o_tx_done    (tx_done)
    );

    // Upstream divider model: flag rises once every 8 clk while running.
    always @(posedge clk) begin
        if (!div_run) begin
            tick_lvl <= tick_hold;
            divcnt   <= tick_hold ? 3'd4 : 3'd0;
        end else begin
            divcnt <= divcnt + 3'd1;
            if (divcnt == 3'd3)      tick_lvl <= 1'b1;
            else if (divcnt == 3'd7) tick_lvl <= 1'b0;
        end
    end

    // Predicts whether the coming posedge is a tick edge (valid when sampled at negedge).
    always @(posedge clk) tbq <= rst ? 1'b1 : tick_lvl;
    assign tb_tick = tick_lvl & ~tbq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; checks the line holds until the next tick edge, returns at the negedge after it.
    task automatic wait_tick(input logic hold, input string tag, output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (tb_tick) begin
                @(posedge clk);
                @(negedge clk);
                n++;
                got = 1'b1;
            end else begin
                check({tag, "_hold"}, serial_out, hold);
                check({tag, "_nodone"}, tx_done, 1'b0);
                @(negedge clk);
                n++;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $error("FAIL %s_tick_timeout: observed=none expected=tick", tag);
        end
    endtask

    task automatic accept(input logic [7:0] w, input bit keep, input string tag, output int waited);
        tx_valid = 1'b1;
        tx_data  = w;
        waited   = 0;
        while (!tx_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!tx_ready) begin
            checks++;
            failures++;
            $error("FAIL %s_accept_timeout: observed=busy expected=ready", tag);
        end
        @(posedge clk);
        @(negedge clk);
        if (!keep) tx_valid = 1'b0;
        check({tag, "_ready_low"}, tx_ready, 1'b0);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_div_en"}, div_enable, 1'b1);
        check({tag, "_idle_line"}, serial_out, 1'b1);
    endtask

    task automatic run_frame(input logic [7:0] w, input string tag, output int n0);
        logic [15:0] b;
        int          nb;
        int          n;
        logic        prev;
        b    = '0;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1+i] = w[i];
        nb = 9;
`ifdef DIVTICK_TX_PARITY_EN
        b[nb] = ^w;
        nb++;
`endif
        b[nb] = 1'b1;
        nb++;
        prev = 1'b1;
        n0   = 0;
        for (int k = 0; k < nb; k++) begin
            wait_tick(prev, $sformatf("%s_b%0d", tag, k), n);
            if (k == 0) n0 = n;
            check($sformatf("%s_bit%0d", tag, k), serial_out, b[k]);
            prev = b[k];
        end
        wait_tick(prev, {tag, "_end"}, n);
        check({tag, "_done"}, tx_done, 1'b1);
        check({tag, "_ready_back"}, tx_ready, 1'b1);
        check({tag, "_busy_clr"}, busy, 1'b0);
        check({tag, "_div_en_clr"}, div_enable, 1'b0);
        check({tag, "_line_idle"}, serial_out, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        int          w;
        int          n;
        logic [7:0]  pat;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset with flag held high, then idle with no activity.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_serial", serial_out, 1'b1);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_div_en", div_enable, 1'b0);
        check("rst_done", tx_done, 1'b0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("idle40_serial", serial_out, 1'b1);
        check("idle40_ready", tx_ready, 1'b1);
        check("idle40_busy", busy, 1'b0);

        // Flag stuck high: accepted word waits without starting.
        accept(8'hA5, 1'b0, "t2_acc", w);
        repeat (40) @(negedge clk);
        check("stuck_serial", serial_out, 1'b1);
        check("stuck_busy", busy, 1'b1);
        check("stuck_ready", tx_ready, 1'b0);

        div_run = 1'b1;
        run_frame(8'hA5, "t2", n0);
        @(negedge clk);
        check("t2_done_pulse", tx_done, 1'b0);

        // Back-to-back with valid held; data changes after capture.
        accept(8'h01, 1'b1, "t3a_acc", w);
        tx_data = 8'hFF;
        run_frame(8'h01, "t3a", n0);
        accept(8'hFF, 1'b0, "t3b_acc", w);
        check("t3_b2b_immediate", w, 0);
        run_frame(8'hFF, "t3b", n0);
        check("t3_gap_start", n0, 7);

        // Reset during the 4th data bit of 0x3C.
        @(negedge clk);
        accept(8'h3C, 1'b0, "t4_acc", w);
        pat = 8'h3C;
        wait_tick(1'b1, "t4_start", n);
        check("t4_start_bit", serial_out, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_tick(k == 0 ? 1'b0 : pat[k-1], $sformatf("t4_d%0d", k), n);
            check($sformatf("t4_dbit%0d", k), serial_out, pat[k]);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("t4_rst_serial", serial_out, 1'b1);
        check("t4_rst_busy", busy, 1'b0);
        check("t4_rst_div_en", div_enable, 1'b0);
        check("t4_rst_ready", tx_ready, 1'b1);
        check("t4_rst_done", tx_done, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check("t4_post_nodone", tx_done, 1'b0);
            check("t4_post_line", serial_out, 1'b1);
            @(negedge clk);
        end
        accept(8'h3C, 1'b0, "t4r_acc", w);
        run_frame(8'h3C, "t4r", n0);

        // Acceptance on the same edge as a tick: start waits a full period.
        @(negedge clk);
        for (int i = 0; i < 20 && !tb_tick; i++) @(negedge clk);
        check("t5_aligned", tb_tick, 1'b1);
        accept(8'h96, 1'b0, "t5_acc", w);
        check("t5_acc_immediate", w, 0);
        run_frame(8'h96, "t5", n0);
        check("t5_start_delay", n0, 8);

        // Second parity pattern (odd weight); framing follows the build.
        @(negedge clk);
        accept(8'h07, 1'b0, "t6_acc", w);
        run_frame(8'h07, "t6", n0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
